register_dump_reader: RTL

REGISTER_DUMP_READER -- requirements
Module: register_dump_reader

---
 rtl/register_dump_reader.sv | 79 +++++++
 1 files changed

// File: rtl/register_dump_reader.sv
// register_dump_reader: walks a register-file read port over FIRST_REG..LAST_REG
// and presents each captured word on a valid/ready stream, then pulses done.
module register_dump_reader #(
    parameter int FIRST_REG = 0,
    parameter int LAST_REG  = 31
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_i,
    input  logic        abort_i,
    output logic [4:0]  read_register_o,
    input  logic [31:0] read_data_i,
    output logic [31:0] dump_data_o,
    output logic [4:0]  dump_index_o,
    output logic        dump_valid_o,
    input  logic        dump_ready_i,
    output logic        busy_o,
    output logic        done_o
);
    typedef enum logic [1:0] {IDLE, ISSUE, HOLD, DONE} state_t;
    state_t      state, state_nx;
    logic [4:0]  index, index_nx;
    logic [31:0] data_nx;
    logic [4:0]  dump_index_nx;
    logic        valid_nx;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            index        <= '0;
            dump_data_o  <= '0;
            dump_index_o <= '0;
            dump_valid_o <= 1'b0;
        end else begin
            state        <= state_nx;
            index        <= index_nx;
            dump_data_o  <= data_nx;
            dump_index_o <= dump_index_nx;
            dump_valid_o <= valid_nx;
        end
    end
    always_comb begin
        state_nx      = state;
        index_nx      = index;
        data_nx       = dump_data_o;
        dump_index_nx = dump_index_o;
        valid_nx      = dump_valid_o;
        // abort outranks ready/start in every non-idle state
        if (abort_i && state != IDLE) begin
            state_nx = IDLE;
            valid_nx = 1'b0;
        end else begin
            case (state)
                IDLE: if (start_i && !abort_i) begin
                    state_nx = ISSUE;
                    index_nx = 5'(FIRST_REG);
                end
                ISSUE: begin
                    data_nx       = read_data_i;
                    dump_index_nx = index;
                    valid_nx      = 1'b1;
                    state_nx      = HOLD;
                end
                HOLD: if (dump_ready_i) begin
                    valid_nx = 1'b0;
                    // compare before incrementing so index never wraps from 31
                    if (index == 5'(LAST_REG)) state_nx = DONE;
                    else begin
                        index_nx = index + 5'd1;
                        state_nx = ISSUE;
                    end
                end
                DONE: state_nx = IDLE;
            endcase
        end
    end
    assign read_register_o = index;
    assign busy_o          = (state == ISSUE) || (state == HOLD);
    assign done_o          = (state == DONE);
endmodule
